rx_block_buffer: RTL
====================

Name: rx_block_buffer

Overview:
Upstream stage of the encryption control block. It assembles the UART receiver's byte stream into 128-bit AES plaintext blocks and queues them in a small first-word-fall-through block FIFO. The FIFO head is presented on pt/rx_empty and popped with rx_read. A partial-block inter-byte timeout resynchronises framing after line glitches or truncated transfers.

Parameters:
DEPTH, 4, FIFO depth in 128-bit blocks; power of two, ≥2
ADDR_W, 2, log2(DEPTH)
TIMEOUT, 1000000, idle clk cycles after which a partially assembled block is discarded
TO_W, 20, width of timeout counter; 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
rx_byte  in  8  received byte from UART receiver
rx_byte_valid  in  1  one-cycle strobe, rx_byte valid
pt  out  128  FIFO head block (first-word-fall-through)
rx_empty  out  1  high when FIFO holds no complete block
rx_read  in  1  pop FIFO head at end of this cycle
rx_level  out  ADDR_W+1  number of stored blocks, 0..DEPTH
rx_overflow  out  1  sticky: a completed block was dropped because FIFO full

Behaviour:
- Reset, applied when reset=0 at a clk edge:
  - rx_empty=1, rx_level=0, rx_overflow=0, pt=0.
  - Byte counter, shift register, timeout counter, pointers and all FIFO memory entries are cleared.
  - Any partial block is lost. Reset mid-operation is equivalent to power-on.
- Assembly:
  - 4-bit byte_cnt (0..15) and 120-bit shift register.
  - On rx_byte_valid with byte_cnt<15: shift rx_byte in at the LSB end and increment byte_cnt.
  - On rx_byte_valid with byte_cnt==15: the completed block is {shreg[119:0], rx_byte}. Push it and set byte_cnt=0.
  - Byte order: the first received byte lands in pt[127:120]; the 16th lands in pt[7:0].
- Push/pop:
  - Push occurs on the edge ending the 16th byte's valid cycle. The block is visible (rx_empty=0, pt updated if the FIFO was empty) the next cycle.
  - Pop occurs when rx_read=1 and rx_empty=0. rd_ptr advances at the edge. The new head, or rx_empty=1, is visible the next cycle.
  - rx_read while empty is ignored; no pointer or level change.
  - Each cycle with rx_read=1 and non-empty pops exactly one block. Consumers must pulse rx_read for one cycle per block.
  - pt = mem[rd_ptr], combinational read. pt is stable while no pop occurs. Contents are don't-care while rx_empty=1, except 0 after reset.
- Full / simultaneous cases:
  - Push with level==DEPTH and no simultaneous pop: block dropped, rx_overflow set to 1 (sticky until reset), level unchanged.
  - Push and pop in the same cycle with level==DEPTH: both happen and level stays DEPTH. Push is accepted, no overflow.
  - Push and pop in the same cycle with 0<level<DEPTH: level unchanged.
  - Push while empty with rx_read=1: push happens, read ignored, level becomes 1.
- Pointers wrap modulo DEPTH. Level is tracked separately in ADDR_W+1 bits: rx_level = count register, rx_empty = (count==0).
- Timeout:
  - The counter is cleared on every rx_byte_valid and while byte_cnt==0.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT with byte_cnt≠0: byte_cnt=0, shift register is not required to clear, counter cleared, no push, no flag.
  - A byte arriving on the same cycle the counter reaches TIMEOUT wins: the byte is accepted and there is no discard.
- No combinational path from rx_read or rx_byte_valid to rx_empty or rx_level. Only the pt mux depends on registered rd_ptr.

Test Plan:
1. Send 16 bytes 0x00..0x0F with arbitrary gaps -> one cycle after 16th strobe: rx_empty=0, rx_level=1, pt=128'h000102030405060708090A0B0C0D0E0F.
2. From case 1, rx_read=1 for one cycle -> next cycle rx_empty=1, rx_level=0. Then rx_read=1 while empty -> no change, rx_overflow=0.
3. Push 4 blocks (bytes 0xA0+i repeated), then a 5th block -> rx_level=4, rx_overflow=1, pt = first block. Four single pops return blocks 1..4 in order, then rx_empty=1.
4. Fill to 4 blocks; assert rx_read in the same cycle as the 16th strobe of a new block -> rx_level stays 4, rx_overflow=0, and the new block emerges 4th after further pops.
5. TIMEOUT=50: send 5 bytes, idle 50 cycles, then 16 bytes 0x10..0x1F -> exactly one block, pt=128'h101112...1F. Repeat with the 6th byte arriving on cycle 50 -> it is treated as byte 6, no discard.
6. With 2 blocks stored and 8 bytes assembled, pull reset low for 1 cycle -> rx_empty=1, rx_level=0, rx_overflow=0, pt=0. A following 16 bytes 0x20..0x2F yield pt=128'h2021...2F.

Source files
------------

// File: rtl/rx_block_buffer.sv
// rx_block_buffer: turns the UART receiver's byte stream into 128-bit AES
// plaintext blocks and queues them in a small first-word-fall-through FIFO.
// A partial block is discarded if the line goes idle for TIMEOUT cycles,
// so framing recovers after glitches or truncated transfers.
module rx_block_buffer #(
    parameter int DEPTH   = 4,        // FIFO depth in blocks, power of two, >= 2
    parameter int ADDR_W  = 2,        // log2(DEPTH)
    parameter int TIMEOUT = 1000000,  // idle cycles before a partial block is dropped
    parameter int TO_W    = 20        // timeout counter width, 2**TO_W > TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,          // synchronous, active-low
    input  logic [7:0]        rx_byte,
    input  logic              rx_byte_valid,
    output logic [127:0]      pt,
    output logic              rx_empty,
    input  logic              rx_read,
    output logic [ADDR_W:0]   rx_level,
    output logic              rx_overflow
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Block assembly state
    // ------------------------------------------------------------------
    logic [3:0]        byte_cnt;
    logic [119:0]      shreg;
    logic [TO_W-1:0]   to_cnt;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [127:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;

    // The 16th byte completes the block; it goes straight into the FIFO
    // together with the 15 bytes already in the shift register.
    logic              push_req;
    logic              pop;
    logic              push_ok;
    logic [127:0]      block;

    assign push_req = rx_byte_valid && (byte_cnt == 4'd15);
    assign block    = {shreg, rx_byte};

    // A pop needs a stored block; a read on an empty FIFO is ignored even
    // if a push lands in the same cycle.
    assign pop      = rx_read && (count != '0);

    // When full, a simultaneous pop frees the slot the push will use.
    assign push_ok  = push_req && ((count != FULL_LEVEL) || pop);

    // Shift bytes in, count them, and drop a stale partial block on timeout.
    // NOTE: all state registers use non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
            to_cnt   <= '0;
        end else if (rx_byte_valid) begin
            // A byte always wins over a timeout expiring in the same cycle.
            to_cnt <= '0;
            shreg  <= {shreg[111:0], rx_byte};
            if (byte_cnt == 4'd15) begin
                byte_cnt <= '0;
            end else begin
                byte_cnt <= byte_cnt + 4'd1;
            end
        end else if (byte_cnt == 4'd0) begin
            // Nothing partial to protect; hold the counter at zero.
            to_cnt <= '0;
        end else if (to_cnt == TO_LAST) begin
            // Counter reaches TIMEOUT at this edge: restart framing.
            // The shift register is left alone; the next 15 bytes refill it.
            byte_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Write completed blocks into the FIFO storage.
    // NOTE: the storage is cleared on reset so pt reads zero afterwards;
    // this makes it a register array rather than a RAM macro, which is
    // acceptable at this depth.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= block;
        end
    end

    // Advance the pointers and track the fill level and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    // Status comes from registered state only; the head is a read of the
    // registered rd_ptr, giving first-word-fall-through behaviour.
    assign rx_level = count;
    assign rx_empty = (count == '0);
    assign pt       = mem[rd_ptr];

endmodule
